sub_bytes_seq: RTL and testbench

//  Iterative forward AES SubBytes engine for the encryption datapath.

---
 rtl/sub_bytes_seq.sv | 120 ++++++++++++
 tb/tb_sub_bytes_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes: BYTES_PER_CYCLE shared S-box lookups per clock, 16/BPC clocks per block.
// The result waits in HOLD under backpressure; in_ready re-opens combinationally from out_ready.
module sbox_unit (
  input  logic [7:0] inputByte,
  output logic [7:0] byteSOut
);
  // Forward S-box, S(0x00) in the top byte so the table reads in natural order.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign byteSOut = SBOX[{~inputByte, 3'b000} +: 8];
endmodule

module sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] inputData,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] byteSubData,
  output logic         busy
);
  localparam int NUM_ITERS = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W     = (NUM_ITERS > 1) ? $clog2(NUM_ITERS) : 1;
  localparam int LOG_BPC   = $clog2(BYTES_PER_CYCLE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ITERS - 1);

  typedef enum logic [1:0] {IDLE, SUB, HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [127:0]     r_work, w_work_nxt, w_sub_work;
  logic [3:0]       w_base;
  logic [7:0]       w_sb_in  [BYTES_PER_CYCLE];
  logic [7:0]       w_sb_out [BYTES_PER_CYCLE];
  logic             w_accept;

  // First byte index of the current window; windows tile the state from byte 0 upward.
  assign w_base = 4'(r_cnt) << LOG_BPC;

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
    assign w_sb_in[g] = r_work[{w_base + 4'(g), 3'b000} +: 8];
    sbox_unit u_sbox (
      .inputByte (w_sb_in[g]),
      .byteSOut  (w_sb_out[g])
    );
  end

  always_comb begin
    w_sub_work = r_work;
    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
      w_sub_work[{w_base + 4'(k), 3'b000} +: 8] = w_sb_out[k];
    end
  end

  assign in_ready    = (r_state == IDLE) | ((r_state == HOLD) & out_ready);
  assign w_accept    = in_valid & in_ready;
  assign out_valid   = (r_state == HOLD);
  assign busy        = (r_state != IDLE);
  assign byteSubData = r_work;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_work_nxt  = r_work;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_work_nxt  = inputData;
          w_cnt_nxt   = '0;
          w_state_nxt = SUB;
        end
      end
      SUB: begin
        w_work_nxt = w_sub_work;
        if (r_cnt == LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = HOLD;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        // Transfer and a new accept can share one edge, so blocks stream with no bubble.
        if (w_accept) begin
          w_work_nxt  = inputData;
          w_cnt_nxt   = '0;
          w_state_nxt = SUB;
        end else if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_work  <= w_work_nxt;
    end
  end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq at BYTES_PER_CYCLE = 4, 1 and 16 side by side.
module tb_sub_bytes_seq;
  localparam int ND = 3;

  function automatic int bpc_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 16;
  endfunction

  function automatic int iters_of(input int d);
    return 16 / bpc_of(d);
  endfunction

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid  [ND];
  logic         in_ready  [ND];
  logic         out_valid [ND];
  logic         out_ready [ND];
  logic         busy      [ND];
  logic [127:0] in_data   [ND];
  logic [127:0] out_data  [ND];

  vec_t tbl [5];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    sub_bytes_seq #(.BYTES_PER_CYCLE(bpc_of(g))) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid[g]),
      .in_ready    (in_ready[g]),
      .inputData   (in_data[g]),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready[g]),
      .byteSubData (out_data[g]),
      .busy        (busy[g])
    );
  end

  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s bpc=%0d: got %h want %h", nm, bpc_of(d), act, exp);
    end
  endtask

  task automatic chk_reset(input int d);
    chk("rst_in_ready", d, 128'(in_ready[d]), 128'd1);
    chk("rst_out_valid", d, 128'(out_valid[d]), 128'd0);
    chk("rst_busy", d, 128'(busy[d]), 128'd0);
    chk("rst_data", d, out_data[d], 128'd0);
  endtask

  // One block through the DUT, optionally stalling the output for 'stall' cycles in HOLD.
  task automatic xfer(input int d, input logic [127:0] din, input logic [127:0] exp, input int stall);
    int i;
    int lat;
    @(posedge clk); #1;
    in_valid[d] = 1'b1; in_data[d] = din; out_ready[d] = (stall == 0);
    #1;
    i = 0;
    while (!in_ready[d] && i < 50) begin @(posedge clk); #2; i++; end
    chk("accept_ready", d, 128'(in_ready[d]), 128'd1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    #1;
    chk("sub_busy", d, 128'(busy[d]), 128'd1);
    lat = 0;
    while (!out_valid[d] && lat < 40) begin @(posedge clk); #2; lat++; end
    chk("latency", d, 128'(lat), 128'(iters_of(d)));
    chk("result", d, out_data[d], exp);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #2;
      chk("stall_valid", d, 128'(out_valid[d]), 128'd1);
      chk("stall_data", d, out_data[d], exp);
      chk("stall_in_ready", d, 128'(in_ready[d]), 128'd0);
    end
    out_ready[d] = 1'b1;
    @(posedge clk); #2;
    chk("post_valid", d, 128'(out_valid[d]), 128'd0);
    chk("post_busy", d, 128'(busy[d]), 128'd0);
    @(posedge clk); #2;
    chk("single_xfer", d, 128'(out_valid[d]), 128'd0);
  endtask

  // Streams vectors 0..2 with in_valid and out_ready held high.
  task automatic b2b(input int d);
    int acc, got, last;
    bit will_acc;
    @(posedge clk); #1;
    in_valid[d] = 1'b1; in_data[d] = tbl[0].din; out_ready[d] = 1'b1;
    acc = 0; got = 0; last = -1;
    for (int cyc = 0; cyc < 200 && got < 3; cyc++) begin
      #1;
      will_acc = in_valid[d] & in_ready[d];
      if (out_valid[d]) begin
        chk("b2b_data", d, out_data[d], tbl[got].dout);
        if (got > 0) chk("b2b_interval", d, 128'(cyc - last), 128'(iters_of(d) + 1));
        last = cyc;
        got++;
      end
      @(posedge clk); #1;
      if (will_acc) begin
        acc++;
        if (acc < 3) in_data[d] = tbl[acc].din;
        else in_valid[d] = 1'b0;
      end
    end
    chk("b2b_count", d, 128'(got), 128'd3);
    in_valid[d] = 1'b0;
  endtask

  // Reset while cnt==2 inside SUB: block is dropped, next block is still correct.
  task automatic rst_mid_sub(input int d);
    bit seen;
    @(posedge clk); #1;
    in_valid[d] = 1'b1; in_data[d] = tbl[0].din; out_ready[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_reset(d);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < iters_of(d) + 5; c++) begin
      @(posedge clk); #2;
      seen |= out_valid[d];
    end
    chk("dropped_block", d, 128'(seen), 128'd0);
    xfer(d, tbl[3].din, tbl[3].dout, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
    tbl[1] = '{128'ha49c7ff2689f352b6b5bea43026a5049, 128'h49ded28945db96f17f39871a7702533b};
    tbl[2] = '{128'haa8f5f0361dde3ef82d24ad26832469a, 128'hac73cf7befc111df13b5d6b545235ab8};
    tbl[3] = '{128'h0, 128'h63636363636363636363636363636363};
    tbl[4] = '{128'hffffffffffffffffffffffffffffffff, 128'h16161616161616161616161616161616};
    for (int d = 0; d < ND; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; in_data[d] = '0;
    end

    #12 rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) chk_reset(d);
    #10 rst = 1'b0;

    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 5; i++) xfer(d, tbl[i].din, tbl[i].dout, 0);
      xfer(d, tbl[0].din, tbl[0].dout, 10);
      b2b(d);
      if (iters_of(d) >= 4) rst_mid_sub(d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
